warp_fetch_unit: RTL and testbench

Parametrised multi-port instruction fetch stage for the SIMT core, between the warp scheduler (one-hot grants, per-warp PC file) and dual/multi decode. Each port selects one warp's PC by one-hot grant, issues a fixed-latency I-cache read, and tracks warp identity and PC+4 alongside the request. Each port has a skid FIFO with ready/valid backpressure toward decode. Per-warp flush kills in-flight and buffered instructions of that warp.

---
 rtl/warp_fetch_unit_if.sv | 38 +++
 rtl/warp_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_warp_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_fetch_unit_if.sv
// rtl/warp_fetch_unit_if.sv - scheduler/I-cache/decode bundle for warp_fetch_unit
// master: environment side; slave: the fetch unit.
interface warp_fetch_unit_if #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_PORTS = 2,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int IMEM_AW   = 10
);
  logic [NUM_WARPS*PC_W-1:0]      pc_flat;
  logic [NUM_WARPS-1:0]           pc_valid;
  logic [NUM_PORTS*NUM_WARPS-1:0] grant;
  logic [NUM_WARPS-1:0]           flush;
  logic [NUM_PORTS-1:0]           grant_ack;
  logic [NUM_PORTS-1:0]           port_busy;
  logic [NUM_PORTS-1:0]           imem_req;
  logic [NUM_PORTS*IMEM_AW-1:0]   imem_addr;
  logic [NUM_PORTS*INSTR_W-1:0]   imem_rdata;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0]           out_ready;
  logic [NUM_PORTS*INSTR_W-1:0]   out_instr;
  logic [NUM_PORTS*NUM_WARPS-1:0] out_warp;
  logic [NUM_PORTS*PC_W-1:0]      out_pc_plus4;
  logic [NUM_PORTS*32-1:0]        perf_fetch_cnt;
  logic [NUM_PORTS*32-1:0]        perf_kill_cnt;

  modport master (
    output pc_flat, pc_valid, grant, flush, imem_rdata, out_ready,
    input  grant_ack, port_busy, imem_req, imem_addr, out_valid, out_instr,
           out_warp, out_pc_plus4, perf_fetch_cnt, perf_kill_cnt
  );

  modport slave (
    input  pc_flat, pc_valid, grant, flush, imem_rdata, out_ready,
    output grant_ack, port_busy, imem_req, imem_addr, out_valid, out_instr,
           out_warp, out_pc_plus4, perf_fetch_cnt, perf_kill_cnt
  );
endinterface

// File: rtl/warp_fetch_unit.sv
// rtl/warp_fetch_unit.sv - multi-port warp fetch: one-hot grant, fixed-latency I-cache, skid FIFO, per-warp flush
// Optional performance counters are built when WARP_FETCH_PERF_EN is defined.
module warp_fetch_unit #(
  parameter int NUM_WARPS  = 8,
  parameter int NUM_PORTS  = 2,
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int IMEM_AW    = 10,
  parameter int MEM_LAT    = 2,
  parameter int SKID_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  warp_fetch_unit_if.slave fetch_io
);
  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int LAST  = MEM_LAT - 1;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [NUM_WARPS-1:0] grant_w;
    logic [PC_W-1:0]      sel_pc;
    logic                 one_hot;
    logic                 eligible;
    logic                 busy;
    logic                 ack;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W:0]       occ;

    logic                 pipe_vld_q  [MEM_LAT];
    logic                 pipe_live_q [MEM_LAT];
    logic [NUM_WARPS-1:0] pipe_warp_q [MEM_LAT];
    logic [PC_W-1:0]      pipe_pc4_q  [MEM_LAT];

    logic                 mem_live_q  [SKID_DEPTH];
    logic [NUM_WARPS-1:0] mem_warp_q  [SKID_DEPTH];
    logic [PC_W-1:0]      mem_pc4_q   [SKID_DEPTH];
    logic [INSTR_W-1:0]   mem_instr_q [SKID_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic push, push_live, pop, head_live, nonempty, valid;

    assign grant_w  = fetch_io.grant[p*NUM_WARPS +: NUM_WARPS];
    assign one_hot  = (grant_w != '0) && ((grant_w & (grant_w - NUM_WARPS'(1))) == '0);
    assign eligible = |(grant_w & fetch_io.pc_valid & ~fetch_io.flush);

    // OR-mux is exact whenever the grant is one-hot, which is the only case it is used.
    always_comb begin
      sel_pc = '0;
      for (int w = 0; w < NUM_WARPS; w++)
        if (grant_w[w]) sel_pc = sel_pc | fetch_io.pc_flat[w*PC_W +: PC_W];
    end

    always_comb begin
      inflight = '0;
      for (int k = 0; k < MEM_LAT; k++) inflight = inflight + CNT_W'(pipe_vld_q[k]);
    end

    // Credit check ignores a same-cycle pop so busy never depends on out_ready.
    assign occ  = {1'b0, count_q} + {1'b0, inflight} + (CNT_W+1)'(1);
    assign busy = occ > (CNT_W+1)'(SKID_DEPTH);
    assign ack  = one_hot && eligible && !busy;

    assign fetch_io.grant_ack[p]                   = ack;
    assign fetch_io.port_busy[p]                   = busy;
    assign fetch_io.imem_req[p]                    = ack;
    assign fetch_io.imem_addr[p*IMEM_AW +: IMEM_AW] = sel_pc[IMEM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < MEM_LAT; k++) begin
          pipe_vld_q[k]  <= 1'b0;
          pipe_live_q[k] <= 1'b0;
          pipe_warp_q[k] <= '0;
          pipe_pc4_q[k]  <= '0;
        end
      end else begin
        pipe_vld_q[0]  <= ack;
        pipe_live_q[0] <= ack;
        pipe_warp_q[0] <= grant_w;
        pipe_pc4_q[0]  <= sel_pc + PC_W'(4);
        for (int k = 1; k < MEM_LAT; k++) begin
          pipe_vld_q[k]  <= pipe_vld_q[k-1];
          pipe_live_q[k] <= pipe_live_q[k-1] && !(|(pipe_warp_q[k-1] & fetch_io.flush));
          pipe_warp_q[k] <= pipe_warp_q[k-1];
          pipe_pc4_q[k]  <= pipe_pc4_q[k-1];
        end
      end
    end

    assign push      = pipe_vld_q[LAST];
    assign push_live = pipe_live_q[LAST] && !(|(pipe_warp_q[LAST] & fetch_io.flush));
    assign nonempty  = count_q != '0;
    assign head_live = mem_live_q[rd_ptr_q];
    assign valid     = nonempty && head_live;
    assign pop       = nonempty && (!head_live || fetch_io.out_ready[p]);

    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SKID_DEPTH; i++) begin
          mem_live_q[i]  <= 1'b0;
          mem_warp_q[i]  <= '0;
          mem_pc4_q[i]   <= '0;
          mem_instr_q[i] <= '0;
        end
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        for (int i = 0; i < SKID_DEPTH; i++)
          if (|(mem_warp_q[i] & fetch_io.flush)) mem_live_q[i] <= 1'b0;
        if (push) begin
          mem_live_q[wr_ptr_q]  <= push_live;
          mem_warp_q[wr_ptr_q]  <= pipe_warp_q[LAST];
          mem_pc4_q[wr_ptr_q]   <= pipe_pc4_q[LAST];
          mem_instr_q[wr_ptr_q] <= fetch_io.imem_rdata[p*INSTR_W +: INSTR_W];
        end
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    assign fetch_io.out_valid[p]                        = valid;
    assign fetch_io.out_instr[p*INSTR_W +: INSTR_W]      = valid ? mem_instr_q[rd_ptr_q] : '0;
    assign fetch_io.out_warp[p*NUM_WARPS +: NUM_WARPS]   = valid ? mem_warp_q[rd_ptr_q] : '0;
    assign fetch_io.out_pc_plus4[p*PC_W +: PC_W]         = valid ? mem_pc4_q[rd_ptr_q] : '0;

`ifdef WARP_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, kill_cnt_q, kill_cnt_d;
    assign fetch_cnt_d = fetch_cnt_q + 32'(ack);
    assign kill_cnt_d  = kill_cnt_q + 32'(pop && !head_live);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fetch_cnt_q <= '0;
        kill_cnt_q  <= '0;
      end else begin
        fetch_cnt_q <= fetch_cnt_d;
        kill_cnt_q  <= kill_cnt_d;
      end
    end
    assign fetch_io.perf_fetch_cnt[p*32 +: 32] = fetch_cnt_q;
    assign fetch_io.perf_kill_cnt[p*32 +: 32]  = kill_cnt_q;
`else
    assign fetch_io.perf_fetch_cnt[p*32 +: 32] = '0;
    assign fetch_io.perf_kill_cnt[p*32 +: 32]  = '0;
`endif
  end
endmodule

// File: tb/tb_warp_fetch_unit.sv
// tb/tb_warp_fetch_unit.sv - randomized + directed bench for warp_fetch_unit against a queue model
// Perf expectations follow WARP_FETCH_PERF_EN.
module tb_warp_fetch_unit;
  localparam int NW = 8, NP = 2, PCW = 32, IW = 32, AW = 10, LAT = 2, D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  warp_fetch_unit_if #(.NUM_WARPS(NW), .NUM_PORTS(NP), .PC_W(PCW), .INSTR_W(IW), .IMEM_AW(AW)) fif ();

  warp_fetch_unit #(.NUM_WARPS(NW), .NUM_PORTS(NP), .PC_W(PCW), .INSTR_W(IW), .IMEM_AW(AW),
                    .MEM_LAT(LAT), .SKID_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .fetch_io(fif));

  logic [PCW-1:0] pcs [NW];
  logic [NW-1:0]  gr  [NP];
  logic [IW-1:0]  imem [1024];
  logic           hist_req  [NP][LAT];
  logic [AW-1:0]  hist_addr [NP][LAT];

  always_comb begin
    fif.pc_flat = '0;
    for (int w = 0; w < NW; w++) fif.pc_flat[w*PCW +: PCW] = pcs[w];
  end
  always_comb begin
    fif.grant = '0;
    for (int p = 0; p < NP; p++) fif.grant[p*NW +: NW] = gr[p];
  end

  // I-cache model: data for a request appears exactly LAT cycles later, garbage otherwise.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      for (int k = LAT-1; k > 0; k--) begin
        hist_req[p][k]  <= hist_req[p][k-1];
        hist_addr[p][k] <= hist_addr[p][k-1];
      end
      hist_req[p][0]  <= fif.imem_req[p];
      hist_addr[p][0] <= fif.imem_addr[p*AW +: AW];
    end
  end
  always_comb begin
    fif.imem_rdata = '0;
    for (int p = 0; p < NP; p++)
      fif.imem_rdata[p*IW +: IW] = hist_req[p][LAT-1] ? imem[hist_addr[p][LAT-1]] : (32'hBAD0_0000 | IW'(p));
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int             ready;
    bit             live;
    logic [NW-1:0]  warp;
    logic [PCW-1:0] pc4;
    logic [IW-1:0]  instr;
  } ent_t;

  ent_t mq [NP][$];
  int   kills_m [NP];
  int   fetch_m [NP];
  int   cyc = 0;

  // Model: one ordered queue per port of everything accepted and not yet popped.
  always @(negedge clk) begin
    logic [NW-1:0] g;
    int   w;
    bit   e_busy, e_ack, avail, e_valid;
    ent_t e;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        mq[p].delete();
        kills_m[p] = 0;
        fetch_m[p] = 0;
      end else begin
        g = gr[p];
        w = 0;
        for (int i = 0; i < NW; i++) if (g[i]) w = i;
        e_busy = (mq[p].size() + 1) > D;
        e_ack  = ($countones(g) == 1) && fif.pc_valid[w] && !fif.flush[w] && !e_busy;
        chk($sformatf("busy%0d", p), fif.port_busy[p], e_busy);
        chk($sformatf("ack%0d", p), fif.grant_ack[p], e_ack);
        chk($sformatf("req%0d", p), fif.imem_req[p], e_ack);
        if (e_ack) chk($sformatf("addr%0d", p), fif.imem_addr[p*AW +: AW], pcs[w][AW+1:2]);
        avail   = (mq[p].size() > 0) && (mq[p][0].ready <= cyc);
        e_valid = avail && mq[p][0].live;
        chk($sformatf("valid%0d", p), fif.out_valid[p], e_valid);
        if (e_valid) begin
          chk($sformatf("instr%0d", p), fif.out_instr[p*IW +: IW], mq[p][0].instr);
          chk($sformatf("warp%0d", p), fif.out_warp[p*NW +: NW], mq[p][0].warp);
          chk($sformatf("pc4_%0d", p), fif.out_pc_plus4[p*PCW +: PCW], mq[p][0].pc4);
        end
`ifdef WARP_FETCH_PERF_EN
        chk($sformatf("pfetch%0d", p), fif.perf_fetch_cnt[p*32 +: 32], fetch_m[p]);
        chk($sformatf("pkill%0d", p), fif.perf_kill_cnt[p*32 +: 32], kills_m[p]);
`else
        chk($sformatf("pfetch%0d", p), fif.perf_fetch_cnt[p*32 +: 32], 0);
        chk($sformatf("pkill%0d", p), fif.perf_kill_cnt[p*32 +: 32], 0);
`endif
        if (avail && (!mq[p][0].live || fif.out_ready[p])) begin
          if (!mq[p][0].live) kills_m[p]++;
          void'(mq[p].pop_front());
        end
        for (int i = 0; i < mq[p].size(); i++)
          if ((mq[p][i].warp & fif.flush) != '0) mq[p][i].live = 1'b0;
        if (e_ack) begin
          e.ready = cyc + LAT + 1;
          e.live  = 1'b1;
          e.warp  = g;
          e.pc4   = pcs[w] + 32'd4;
          e.instr = imem[pcs[w][AW+1:2]];
          mq[p].push_back(e);
          fetch_m[p]++;
        end
      end
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) gr[p] = '0;
    fif.flush     = '0;
    fif.pc_valid  = '1;
    fif.out_ready = '1;
  endtask

  task automatic single_fetch(string tag);
    pcs[2] = 32'h40;
    gr[0]  = 8'b0000_0100;
    @(negedge clk);
    chk({tag, "_ack"}, fif.grant_ack[0], 1);
    chk({tag, "_addr"}, fif.imem_addr[AW-1:0], 10'h10);
    nxt();
    gr[0] = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_valid_t%0d", tag, k), fif.out_valid[0], k == 3);
      if (k < 3) nxt();
    end
    chk({tag, "_instr"}, fif.out_instr[IW-1:0], 32'hDEAD_BEEF);
    chk({tag, "_warp"}, fif.out_warp[NW-1:0], 8'h04);
    chk({tag, "_pc4"}, fif.out_pc_plus4[PCW-1:0], 32'h44);
    nxt();
  endtask

  initial begin
    int cnt, busy_cnt, first, last;
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[16] = 32'hDEAD_BEEF;
    for (int w = 0; w < NW; w++) pcs[w] = 32'h1000 + 32'h200 * w;
    for (int p = 0; p < NP; p++) for (int k = 0; k < LAT; k++) begin
      hist_req[p][k] = 1'b0;
      hist_addr[p][k] = '0;
    end
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", fif.out_valid, 0);
    chk("rst_instr", fif.out_instr, 0);
    chk("rst_warp", fif.out_warp, 0);
    chk("rst_pc4", fif.out_pc_plus4, 0);
    chk("rst_pfetch", fif.perf_fetch_cnt, 0);
    chk("rst_pkill", fif.perf_kill_cnt, 0);
    chk("rst_busy", fif.port_busy, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    single_fetch("single");

    // Flush: warp1, warp2, warp1 pending on port 0, flush warp1 while held back.
    fif.out_ready[0] = 1'b0;
    pcs[1] = 32'h80;
    pcs[2] = 32'h90;
    gr[0] = 8'b0000_0010; nxt();
    gr[0] = 8'b0000_0100; nxt();
    gr[0] = 8'b0000_0010; nxt();
    gr[0] = '0; fif.flush = 8'b0000_0010; nxt();
    fif.flush = '0; nxt();
    fif.out_ready[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (fif.out_valid[0]) begin
        cnt++;
        chk("flush_warp", fif.out_warp[NW-1:0], 8'h04);
      end
      nxt();
    end
    chk("flush_survivors", cnt, 1);
`ifdef WARP_FETCH_PERF_EN
    chk("flush_kill_cnt", fif.perf_kill_cnt[31:0], 2);
    chk("flush_fetch_cnt", fif.perf_fetch_cnt[31:0], 4);
`else
    chk("flush_kill_cnt", fif.perf_kill_cnt[31:0], 0);
`endif

    // Streaming on port 0.
    cnt = 0; busy_cnt = 0; first = -1; last = -1;
    for (int k = 0; k < 20 + LAT + 4; k++) begin
      gr[0] = (k < 20) ? 8'b0000_1000 : 8'h00;
      pcs[3] = 32'h200 + 32'(4 * k);
      @(negedge clk);
      if (fif.port_busy[0]) busy_cnt++;
      if (fif.out_valid[0]) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      nxt();
    end
    chk("stream_count", cnt, 20);
    chk("stream_busy", busy_cnt, 0);
    chk("stream_span", last - first, 19);

    // Backpressure on port 1.
    fif.out_ready[1] = 1'b0;
    cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      gr[1] = 8'b0010_0000;
      pcs[5] = 32'h300 + 32'(4 * k);
      @(negedge clk);
      if (fif.grant_ack[1]) cnt++;
      if (fif.port_busy[1]) busy_cnt++;
      nxt();
    end
    chk("bp_accepts", cnt, D);
    chk("bp_busy_seen", busy_cnt > 0, 1);
    gr[1] = '0;
    fif.out_ready[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fif.out_valid[1]) begin
        chk($sformatf("bp_order%0d", cnt), fif.out_pc_plus4[PCW +: PCW], 32'h304 + 32'(4 * cnt));
        cnt++;
      end
      nxt();
    end
    chk("bp_drained", cnt, D);

    // Illegal grants.
    gr[0] = 8'b0000_0011;
    @(negedge clk); chk("ill_multi_ack", fif.grant_ack[0], 0); chk("ill_multi_req", fif.imem_req[0], 0); nxt();
    gr[0] = 8'b0000_0000;
    @(negedge clk); chk("ill_zero_ack", fif.grant_ack[0], 0); nxt();
    gr[0] = 8'b0001_0000; fif.pc_valid[4] = 1'b0;
    @(negedge clk); chk("ill_pcv_ack", fif.grant_ack[0], 0); chk("ill_pcv_req", fif.imem_req[0], 0); nxt();
    fif.pc_valid[4] = 1'b1; gr[0] = 8'b0010_0000; fif.flush[5] = 1'b1;
    @(negedge clk); chk("ill_flush_ack", fif.grant_ack[0], 0); chk("ill_flush_req", fif.imem_req[0], 0); nxt();
    idle();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fif.out_valid[0]) cnt++;
      nxt();
    end
    chk("ill_no_output", cnt, 0);

    // Randomized traffic on both ports.
    for (int k = 0; k < 3000; k++) begin
      for (int w = 0; w < NW; w++) begin
        pcs[w] = $urandom;
        fif.pc_valid[w] = ($urandom_range(0, 9) != 0);
      end
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 9))
          0: gr[p] = '0;
          1: gr[p] = (8'h1 << $urandom_range(0, 3)) | (8'h10 << $urandom_range(0, 3));
          default: gr[p] = 8'h1 << $urandom_range(0, NW - 1);
        endcase
        fif.out_ready[p] = ($urandom_range(0, 3) != 0);
      end
      fif.flush = ($urandom_range(0, 15) == 0) ? (8'h1 << $urandom_range(0, NW - 1)) : 8'h00;
      nxt();
    end

    // Reset mid-stream with port 0 holding buffered and in-flight work.
    idle();
    fif.out_ready[0] = 1'b0;
    repeat (D + 2) nxt();
    for (int k = 0; k < 4; k++) begin
      gr[0] = 8'h1 << k;
      nxt();
    end
    gr[0] = '0;
    @(negedge clk);
    chk("prerst_valid", fif.out_valid[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", fif.out_valid, 0);
    chk("midrst_pc4", fif.out_pc_plus4, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    nxt();
    single_fetch("after_rst");
    repeat (8) nxt();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
